// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared encodings for the multi-cycle integer divider
package div_unit_pkg;

  // Divider FSM states
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Handshake levels seen by the EX stage
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // EX-side aluop codes that route to this unit
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_iter.sv
// rtl/div_unit_iter.sv - one combinational restoring-division step
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] work,
  input  logic [WIDTH-1:0] divisor,
  output logic [2*WIDTH:0] work_next
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Shift in a zero, then try subtracting the divisor from the partial remainder
  always_comb begin
    shifted = work << 1;
    upper   = shifted[2*WIDTH:WIDTH];
    diff    = upper - {1'b0, divisor};
    fits    = (upper >= {1'b0, divisor});
    if (fits) begin
      work_next = {diff, shifted[WIDTH-1:1], 1'b1};
    end else begin
      work_next = shifted;
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring DIV/DIVU unit with flush and divide-by-zero
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state;
  div_state_e       state_next;

  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] work;
  logic [2*WIDTH:0] work_step;
  logic [WIDTH-1:0] divisor_abs;
  logic             neg_q;
  logic             neg_r;
  logic [2*WIDTH-1:0] res;
  logic             zero_flag;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] dividend_abs_in;
  logic [WIDTH-1:0] divisor_abs_in;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] r_raw;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  logic [2*WIDTH-1:0] result_next;
  logic               ready_next;
  logic               busy_next;
  logic               div_zero_next;

  div_iter #(.WIDTH(WIDTH)) u_iter (
    .work      (work),
    .divisor   (divisor_abs),
    .work_next (work_step)
  );

  // Accept conditions, operand magnitudes and the signed fixup of the final step
  always_comb begin
    accept    = (state == DivFree) && start_i && !annul_i;
    last_iter = (state == DivOn) && (cnt == CNT_W'(WIDTH - 1));
    dividend_abs_in = (signed_i && opdata1_i[WIDTH-1]) ? ({WIDTH{1'b0}} - opdata1_i) : opdata1_i;
    divisor_abs_in  = (signed_i && opdata2_i[WIDTH-1]) ? ({WIDTH{1'b0}} - opdata2_i) : opdata2_i;
    q_raw = work_step[WIDTH-1:0];
    r_raw = work_step[2*WIDTH-1:WIDTH];
    // The most-negative / -1 case lands here with equal signs, so it wraps naturally
    q_fix = neg_q ? ({WIDTH{1'b0}} - q_raw) : q_raw;
    r_fix = neg_r ? ({WIDTH{1'b0}} - r_raw) : r_raw;
  end

  // State and registered outputs; reset beats every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DivFree;
      result_o   <= '0;
      ready_o    <= DivResultNotReady;
      busy_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      state      <= state_next;
      result_o   <= result_next;
      ready_o    <= ready_next;
      busy_o     <= busy_next;
      div_zero_o <= div_zero_next;
    end
  end

  // Next-state selection; a flush always returns to DivFree
  always_comb begin
    state_next = state;
    case (state)
      DivFree: begin
        if (start_i && !annul_i) begin
          state_next = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        state_next = annul_i ? DivFree : DivEnd;
      end
      DivOn: begin
        if (annul_i) begin
          state_next = DivFree;
        end else if (last_iter) begin
          state_next = DivEnd;
        end
      end
      DivEnd: begin
        if (annul_i || !start_i) begin
          state_next = DivFree;
        end
      end
      default: state_next = DivFree;
    endcase
  end

  // Output values for the next edge; the result is only presented while EX still requests it
  always_comb begin
    result_next   = '0;
    ready_next    = DivResultNotReady;
    div_zero_next = 1'b0;
    busy_next     = (state_next != DivFree);
    if ((state == DivEnd) && (start_i == DivStart) && !annul_i) begin
      result_next   = res;
      ready_next    = DivResultReady;
      div_zero_next = zero_flag;
    end
  end

  // Datapath: operand capture on accept, one restoring step per DivOn cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      work        <= '0;
      divisor_abs <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      res         <= '0;
      zero_flag   <= 1'b0;
    end else begin
      case (state)
        DivFree: begin
          if (accept) begin
            work        <= {{(WIDTH+1){1'b0}}, dividend_abs_in};
            divisor_abs <= divisor_abs_in;
            neg_q       <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r       <= signed_i && opdata1_i[WIDTH-1];
            cnt         <= '0;
            res         <= '0;
            zero_flag   <= (opdata2_i == '0);
          end
        end
        DivByZero: begin
          res       <= '0;
          zero_flag <= 1'b1;
        end
        DivOn: begin
          if (annul_i) begin
            cnt <= '0;
          end else begin
            work <= work_step;
            cnt  <= cnt + 1'b1;
            if (last_iter) begin
              res       <= {r_fix, q_fix};
              zero_flag <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic        div_zero_o;

  logic        start16;
  logic        signed16;
  logic        annul16;
  logic [15:0] op1_16;
  logic [15:0] op2_16;
  logic [31:0] result16;
  logic        ready16;
  logic        busy16;
  logic        div_zero16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .annul_i    (annul_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .div_zero_o (div_zero_o)
  );

  div_unit #(.WIDTH(16)) dut16 (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start16),
    .signed_i   (signed16),
    .annul_i    (annul16),
    .opdata1_i  (op1_16),
    .opdata2_i  (op2_16),
    .result_o   (result16),
    .ready_o    (ready16),
    .busy_o     (busy16),
    .div_zero_o (div_zero16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Run one division with start held, then check hold and release behaviour
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat, input logic exp_dz);
    int n;
    logic [63:0] seen;
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    @(posedge clk);
    @(negedge clk);
    opdata1_i = $urandom; opdata2_i = $urandom;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready_o && n < 100);
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    check({tag, " div_zero"}, {63'd0, div_zero_o}, {63'd0, exp_dz});
    seen = result_o;
    @(posedge clk); #1;
    check({tag, " ready held"}, {63'd0, ready_o}, 64'd1);
    check({tag, " result held"}, result_o, seen);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " ready cleared"}, {63'd0, ready_o}, 64'd0);
    check({tag, " result cleared"}, result_o, 64'd0);
    check({tag, " busy cleared"}, {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    int n;
    logic saw_ready;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    start16 = 1'b0; signed16 = 1'b0; annul16 = 1'b0; op1_16 = '0; op2_16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", result_o, 64'd0);
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset busy", {63'd0, busy_o}, 64'd0);
    check("reset div_zero", {63'd0, div_zero_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0);
    run_div("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33, 1'b0);
    run_div("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}, 33, 1'b0);
    run_div("div -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h0000_0003}, 33, 1'b0);
    run_div("div by zero", 1'b0, 32'h1234_5678, 32'd0, 64'd0, 2, 1'b1);
    run_div("after zero", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 1'b0);

    // Flush in the middle of an operation
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    @(posedge clk);
    saw_ready = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      saw_ready |= ready_o;
    end
    check("annul busy before", {63'd0, busy_o}, 64'd1);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul busy", {63'd0, busy_o}, 64'd0);
    check("annul ready", {63'd0, ready_o | saw_ready}, 64'd0);
    check("annul result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check("annul idle busy", {63'd0, busy_o}, 64'd0);

    // Annul while idle blocks the accept even with start high
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk); #1;
    check("annul in idle", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;

    run_div("divu ffffffff/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, 1'b0);
    run_div("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 1'b0);
    run_div("divu 0/5", 1'b0, 32'd0, 32'd5, 64'd0, 33, 1'b0);

    // Synchronous reset mid-operation
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    check("rst mid busy", {63'd0, busy_o}, 64'd0);
    check("rst mid ready", {63'd0, ready_o}, 64'd0);
    check("rst mid result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_div("after rst 1000/3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, 1'b0);

    // Narrow instance: 16-bit operands finish in 17 edges
    @(negedge clk);
    start16 = 1'b1; signed16 = 1'b0; op1_16 = 16'hFFFF; op2_16 = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    op1_16 = 16'h0001; op2_16 = 16'h0009;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready16 && n < 100);
    check("w16 latency", 64'(n), 64'd17);
    check("w16 result", {32'd0, result16}, {32'd0, 16'h0000, 16'h5555});
    check("w16 div_zero", {63'd0, div_zero16}, 64'd0);
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk); #1;
    check("w16 ready cleared", {63'd0, ready16}, 64'd0);
    check("w16 busy cleared", {63'd0, busy16}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
